// File: rtl/accel_pkg.sv
// ADXL345 polling sequencer: shared states, register map and init table.
package accel_pkg;

    typedef enum logic [2:0] {
        INIT_REQ  = 3'd0,
        INIT_WAIT = 3'd1,
        IDLE      = 3'd2,
        RD_REQ    = 3'd3,
        RD_WAIT   = 3'd4,
        PUBLISH   = 3'd5,
        BACKOFF   = 3'd6
    } seq_state_e;

    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATAX0      = 8'h32;

    localparam int NUM_DATA_BYTES = 6;
    localparam int INIT_LEN       = 2;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } init_entry_t;

    // Entry 0 (low half) goes out first: full-res +/-16g, then measure mode.
    localparam init_entry_t [INIT_LEN-1:0] INIT_TABLE = {
        {REG_POWER_CTL,   8'h08},
        {REG_DATA_FORMAT, 8'h0B}
    };

    // Register address of data byte idx (DATAX0 .. DATAZ1).
    function automatic logic [7:0] data_reg(input logic [2:0] idx);
        return REG_DATAX0 + {5'd0, idx};
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running frame-rate divider: one-cycle tick every PERIOD cycles.
module sample_tick_gen #(
    parameter int PERIOD = 500000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Wrap at PERIOD-1 so the first tick lands PERIOD cycles after reset release.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Divider state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/accel_poll_sequencer.sv
// Drives the single-byte I2C master: configures the ADXL345, then reads
// DATAX0..DATAZ1 once per frame tick and publishes signed X/Y/Z samples.
module accel_poll_sequencer
    import accel_pkg::*;
#(
    parameter int         SYS_CLK_SPEED  = 50000000,
    parameter int         SAMPLE_RATE_HZ = 100,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         BACKOFF_CYCLES = 1000000,
    parameter logic [6:0] DEV_ADDR       = 7'h1D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        i2c_ready,
    input  logic        i2c_done,
    input  logic [7:0]  i2c_rdata,
    output logic        i2c_start,
    output logic [6:0]  i2c_dev_addr,
    output logic [7:0]  i2c_reg_addr,
    output logic        i2c_rw,
    output logic [7:0]  i2c_wdata,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid,
    output logic        init_done,
    output logic        overrun,
    output logic        timeout_err
);
    localparam int PERIOD  = SYS_CLK_SPEED / SAMPLE_RATE_HZ;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

    // The timeout decision is taken one cycle early so that the registered
    // timeout_err pulse is visible exactly TIMEOUT_CYCLES-1 cycles after start.
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 2);
    localparam logic [CW-1:0] BKO_LAST  = CW'(BACKOFF_CYCLES - 1);
    localparam logic [2:0]    INIT_LAST = 3'(INIT_LEN - 1);
    localparam logic [2:0]    DATA_LAST = 3'(NUM_DATA_BYTES - 1);

    seq_state_e  state_q;
    logic [2:0]  idx_q;
    logic [CW-1:0] cnt_q;
    logic        start_q;
    logic [7:0]  reg_addr_q;
    logic        rw_q;
    logic [7:0]  wdata_q;
    logic [15:0] x_q, y_q, z_q;
    logic        sample_valid_q;
    logic        init_done_q;
    logic        overrun_q;
    logic        timeout_err_q;
    // Bytes 0..4 only; the last byte is taken straight from i2c_rdata at publish.
    logic [NUM_DATA_BYTES-2:0][7:0] byte_q;

    logic tick;

    sample_tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Sequencer FSM with registered request and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= INIT_REQ;
            idx_q          <= '0;
            cnt_q          <= '0;
            start_q        <= 1'b0;
            reg_addr_q     <= '0;
            rw_q           <= 1'b0;
            wdata_q        <= '0;
            x_q            <= '0;
            y_q            <= '0;
            z_q            <= '0;
            byte_q         <= '0;
            sample_valid_q <= 1'b0;
            init_done_q    <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            start_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;

            // Ticks are never queued: one landing mid-frame is only reported.
            if (tick && init_done_q && (state_q != IDLE)) overrun_q <= 1'b1;

            case (state_q)
                INIT_REQ: begin
                    if (enable && i2c_ready) begin
                        start_q    <= 1'b1;
                        reg_addr_q <= INIT_TABLE[idx_q[IW-1:0]].addr;
                        wdata_q    <= INIT_TABLE[idx_q[IW-1:0]].data;
                        rw_q       <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= INIT_WAIT;
                    end
                end

                INIT_WAIT: begin
                    if (i2c_done) begin
                        if (idx_q == INIT_LAST) begin
                            init_done_q <= 1'b1;
                            idx_q       <= '0;
                            state_q     <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= INIT_REQ;
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        timeout_err_q <= 1'b1;
                        init_done_q   <= 1'b0;
                        idx_q         <= '0;
                        cnt_q         <= '0;
                        state_q       <= BACKOFF;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                IDLE: begin
                    if (tick) state_q <= RD_REQ;
                end

                RD_REQ: begin
                    if (enable && i2c_ready) begin
                        start_q    <= 1'b1;
                        reg_addr_q <= data_reg(idx_q);
                        wdata_q    <= '0;
                        rw_q       <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (i2c_done) begin
                        if (idx_q == DATA_LAST) begin
                            x_q            <= {byte_q[1], byte_q[0]};
                            y_q            <= {byte_q[3], byte_q[2]};
                            z_q            <= {i2c_rdata, byte_q[4]};
                            sample_valid_q <= 1'b1;
                            idx_q          <= '0;
                            state_q        <= PUBLISH;
                        end else begin
                            byte_q[idx_q] <= i2c_rdata;
                            idx_q         <= idx_q + 3'd1;
                            state_q       <= RD_REQ;
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        timeout_err_q <= 1'b1;
                        init_done_q   <= 1'b0;
                        idx_q         <= '0;
                        cnt_q         <= '0;
                        state_q       <= BACKOFF;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                PUBLISH: begin
                    state_q <= IDLE;
                end

                BACKOFF: begin
                    if (cnt_q == BKO_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= INIT_REQ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    idx_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= INIT_REQ;
                end
            endcase
        end
    end

    assign i2c_start    = start_q;
    assign i2c_dev_addr = DEV_ADDR;
    assign i2c_reg_addr = reg_addr_q;
    assign i2c_rw       = rw_q;
    assign i2c_wdata    = wdata_q;
    assign accel_x      = x_q;
    assign accel_y      = y_q;
    assign accel_z      = z_q;
    assign sample_valid = sample_valid_q;
    assign init_done    = init_done_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;

endmodule
